pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encodings,
// the per-stage write-enable bundle, and a register-match helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10,
    ST_ILL   = 2'b11
  } state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_we_t;

  localparam stage_we_t WE_ALL  = stage_we_t'(5'b11111);
  localparam stage_we_t WE_NONE = stage_we_t'(5'b00000);

  function automatic logic regHit(
    input logic [2:0] src,
    input logic       vld,
    input logic [2:0] dst,
    input logic       wr
  );
    return vld & wr & (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Controller <-> pipeline bundle: ID sources, stage dests,
// events in; stage enables, flush/bubble, status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       rs_id;
  logic [2:0]       rt_id;
  logic             rs_vld;
  logic             rt_vld;
  logic [2:0]       wr_reg_ex;
  logic             reg_write_ex;
  logic [2:0]       wr_reg_mem;
  logic             reg_write_mem;
  logic [2:0]       wr_reg_wb;
  logic             reg_write_wb;
  logic             redirect_ex;
  logic             halt_id;
  logic             imem_stall;
  logic             dmem_stall;
  logic             err_in;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             memwb_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic             err;

  modport master (
    input  rs_id, rt_id, rs_vld, rt_vld,
    input  wr_reg_ex, reg_write_ex,
    input  wr_reg_mem, reg_write_mem,
    input  wr_reg_wb, reg_write_wb,
    input  redirect_ex, halt_id,
    input  imem_stall, dmem_stall, err_in,
    output pc_we, ifid_we, idex_we,
    output exmem_we, memwb_we,
    output ifid_flush, idex_bubble,
    output halted, stall_cnt, err
  );

  modport slave (
    output rs_id, rt_id, rs_vld, rt_vld,
    output wr_reg_ex, reg_write_ex,
    output wr_reg_mem, reg_write_mem,
    output wr_reg_wb, reg_write_wb,
    output redirect_ex, halt_id,
    output imem_stall, dmem_stall, err_in,
    input  pc_we, ifid_we, idex_we,
    input  exmem_we, memwb_we,
    input  ifid_flush, idex_bubble,
    input  halted, stall_cnt, err
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW detect: ID sources vs in-flight dests.
// Ports: rs/rt + valids, EX/MEM/WB dest + RegWrite -> raw.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit CHECK_WB = 1'b0
) (
  input  logic [2:0] rsId,
  input  logic [2:0] rtId,
  input  logic       rsVld,
  input  logic       rtVld,
  input  logic [2:0] wrRegEx,
  input  logic       regWriteEx,
  input  logic [2:0] wrRegMem,
  input  logic       regWriteMem,
  input  logic [2:0] wrRegWb,
  input  logic       regWriteWb,
  output logic       raw
);

  logic exHit;
  logic memHit;
  logic wbHit;

  assign exHit =
    regHit(rsId, rsVld, wrRegEx, regWriteEx) |
    regHit(rtId, rtVld, wrRegEx, regWriteEx);

  assign memHit =
    regHit(rsId, rsVld, wrRegMem, regWriteMem) |
    regHit(rtId, rtVld, wrRegMem, regWriteMem);

  assign wbHit = CHECK_WB & (
    regHit(rsId, rsVld, wrRegWb, regWriteWb) |
    regHit(rtId, rtVld, wrRegWb, regWriteWb));

  assign raw = exHit | memHit | wbHit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables, flush, bubble, HALT drain.
// Ports: clk, rst (sync, active-high), bus (master modport).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit CHECK_WB     = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e           state;
  state_e           stateNxt;
  logic [DW-1:0]    drainCnt;
  logic [DW-1:0]    drainNxt;
  logic             flushPend;
  logic             flushPendNxt;
  logic [CNT_W-1:0] stallCnt;
  logic             errQ;
  logic             errC;
  logic             raw;
  logic             stallEv;
  stage_we_t        we;
  logic             ifidFlush;
  logic             idexBubble;
  logic             haltedC;

  hazard_detect #(
    .CHECK_WB(CHECK_WB)
  ) u_hazard (
    .rsId       (bus.rs_id),
    .rtId       (bus.rt_id),
    .rsVld      (bus.rs_vld),
    .rtVld      (bus.rt_vld),
    .wrRegEx    (bus.wr_reg_ex),
    .regWriteEx (bus.reg_write_ex),
    .wrRegMem   (bus.wr_reg_mem),
    .regWriteMem(bus.reg_write_mem),
    .wrRegWb    (bus.wr_reg_wb),
    .regWriteWb (bus.reg_write_wb),
    .raw        (raw)
  );

  always_comb begin
    we           = WE_ALL;
    ifidFlush    = 1'b0;
    idexBubble   = 1'b0;
    haltedC      = 1'b0;
    stallEv      = 1'b0;
    stateNxt     = state;
    drainNxt     = drainCnt;
    flushPendNxt = flushPend;
    if (!rst) begin
      unique case (state)
        ST_RUN: begin
          if (bus.dmem_stall) begin
            we      = WE_NONE;
            stallEv = 1'b1;
          end else if (bus.redirect_ex) begin
            ifidFlush    = 1'b1;
            idexBubble   = 1'b1;
            // target fetch not back yet: squash it later
            flushPendNxt = bus.imem_stall;
          end else if (raw) begin
            we.pc      = 1'b0;
            we.ifid    = 1'b0;
            idexBubble = 1'b1;
            stallEv    = 1'b1;
          end else if (bus.imem_stall | flushPend) begin
            we.pc        = ~bus.imem_stall;
            ifidFlush    = 1'b1;
            stallEv      = 1'b1;
            flushPendNxt = flushPend & bus.imem_stall;
          end else if (bus.halt_id) begin
            we.pc    = 1'b0;
            we.ifid  = 1'b0;
            // accept cycle is the first drain cycle
            drainNxt = drainCnt - 1'b1;
            stateNxt = (drainCnt == DW'(1)) ?
                       ST_HALT : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          we.pc     = 1'b0;
          we.ifid   = ~bus.dmem_stall;
          we.idex   = ~bus.dmem_stall;
          we.exmem  = ~bus.dmem_stall;
          we.memwb  = ~bus.dmem_stall;
          ifidFlush = 1'b1;
          if (!bus.dmem_stall) begin
            drainNxt = drainCnt - 1'b1;
            if (drainCnt == DW'(1))
              stateNxt = ST_HALT;
          end
        end
        default: begin
          we      = WE_NONE;
          haltedC = 1'b1;
        end
      endcase
    end
  end

  assign errC = (errQ | bus.err_in |
                 (state == ST_ILL)) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drainCnt  <= DW'(DRAIN_CYCLES);
      flushPend <= 1'b0;
      stallCnt  <= '0;
      errQ      <= 1'b0;
    end else begin
      state     <= stateNxt;
      drainCnt  <= drainNxt;
      flushPend <= flushPendNxt;
      errQ      <= errC;
      if (stallEv && (stallCnt != '1))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  assign bus.pc_we       = we.pc;
  assign bus.ifid_we     = we.ifid;
  assign bus.idex_we     = we.idex;
  assign bus.exmem_we    = we.exmem;
  assign bus.memwb_we    = we.memwb;
  assign bus.ifid_flush  = ifidFlush;
  assign bus.idex_bubble = idexBubble;
  assign bus.halted      = haltedC;
  assign bus.stall_cnt   = stallCnt;
  assign bus.err         = errC;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected outputs
// queued at drive time, popped and checked at negedge.
module tb_pipe_hazard_ctrl;

  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic        err;
    bit          chkCnt;
    logic [15:0] cnt;
  } exp_t;

  // {pc,ifid,idex,exmem,memwb,flush,bubble,halted}
  localparam logic [7:0] ALL   = 8'b11111000;
  localparam logic [7:0] NONE  = 8'b00000000;
  localparam logic [7:0] RAWS  = 8'b00111010;
  localparam logic [7:0] REDIR = 8'b11111110;
  localparam logic [7:0] IMEMB = 8'b01111100;
  localparam logic [7:0] PENDB = 8'b11111100;
  localparam logic [7:0] HALTA = 8'b00111000;
  localparam logic [7:0] DRN   = 8'b01111100;
  localparam logic [7:0] DRNF  = 8'b00000100;
  localparam logic [7:0] HLT   = 8'b00000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bif ();

  pipe_hazard_ctrl #(
    .CHECK_WB    (1'b0),
    .DRAIN_CYCLES(3),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".ctl"},
          {24'd0, bif.pc_we, bif.ifid_we,
           bif.idex_we, bif.exmem_we,
           bif.memwb_we, bif.ifid_flush,
           bif.idex_bubble, bif.halted},
          {24'd0, e.ctl});
      chk({e.tag, ".err"},
          {31'd0, bif.err}, {31'd0, e.err});
      if (e.chkCnt)
        chk({e.tag, ".cnt"},
            {16'd0, bif.stall_cnt},
            {16'd0, e.cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(
    input string      tag,
    input logic [7:0] ctl,
    input logic       err,
    input int         cnt
  );
    exp_t e;
    e.tag    = tag;
    e.ctl    = ctl;
    e.err    = err;
    e.chkCnt = (cnt >= 0);
    e.cnt    = 16'(cnt);
    q.push_back(e);
    tick();
  endtask

  task automatic clearIn();
    bif.rs_id         = 3'd0;
    bif.rt_id         = 3'd0;
    bif.rs_vld        = 1'b0;
    bif.rt_vld        = 1'b0;
    bif.wr_reg_ex     = 3'd0;
    bif.reg_write_ex  = 1'b0;
    bif.wr_reg_mem    = 3'd0;
    bif.reg_write_mem = 1'b0;
    bif.wr_reg_wb     = 3'd0;
    bif.reg_write_wb  = 1'b0;
    bif.redirect_ex   = 1'b0;
    bif.halt_id       = 1'b0;
    bif.imem_stall    = 1'b0;
    bif.dmem_stall    = 1'b0;
    bif.err_in        = 1'b0;
  endtask

  initial begin
    clearIn();
    tick();
    bif.err_in = 1'b1;
    cyc("rst", ALL, 1'b0, -1);
    rst = 1'b0;
    clearIn();
    cyc("idle0", ALL, 1'b0, 0);

    // T1: EX dest matches rs
    bif.reg_write_ex = 1'b1;
    bif.wr_reg_ex    = 3'd3;
    bif.rs_id        = 3'd3;
    bif.rs_vld       = 1'b1;
    cyc("t1raw", RAWS, 1'b0, 0);
    bif.rs_vld = 1'b0;
    cyc("rsInv", ALL, 1'b0, 1);
    clearIn();
    bif.reg_write_mem = 1'b1;
    bif.wr_reg_mem    = 3'd5;
    bif.rt_id         = 3'd5;
    bif.rt_vld        = 1'b1;
    cyc("memRaw", RAWS, 1'b0, 1);
    clearIn();
    bif.reg_write_wb = 1'b1;
    bif.wr_reg_wb    = 3'd2;
    bif.rs_id        = 3'd2;
    bif.rs_vld       = 1'b1;
    cyc("wbNoChk", ALL, 1'b0, 2);
    clearIn();
    bif.wr_reg_ex = 3'd3;
    bif.rs_id     = 3'd3;
    bif.rs_vld    = 1'b1;
    cyc("exNoWr", ALL, 1'b0, 2);

    // T2: redirect beats raw and halt
    bif.reg_write_ex = 1'b1;
    bif.halt_id      = 1'b1;
    bif.redirect_ex  = 1'b1;
    cyc("t2redir", REDIR, 1'b0, 2);
    clearIn();
    cyc("t2run", ALL, 1'b0, 2);

    // T3: redirect under imem stall
    bif.redirect_ex = 1'b1;
    bif.imem_stall  = 1'b1;
    cyc("t3a", REDIR, 1'b0, 2);
    bif.redirect_ex = 1'b0;
    cyc("t3b", IMEMB, 1'b0, 2);
    bif.imem_stall = 1'b0;
    cyc("t3c", PENDB, 1'b0, 3);
    cyc("t3d", ALL, 1'b0, 4);

    bif.imem_stall = 1'b1;
    cyc("imem", IMEMB, 1'b0, 4);
    bif.imem_stall = 1'b0;
    cyc("imemEnd", ALL, 1'b0, 5);

    bif.dmem_stall  = 1'b1;
    bif.redirect_ex = 1'b1;
    cyc("dmemTop", NONE, 1'b0, 5);
    clearIn();
    cyc("dmemEnd", ALL, 1'b0, 6);

    // T4: drain with two frozen cycles
    bif.halt_id = 1'b1;
    cyc("t4acc", HALTA, 1'b0, 6);
    bif.halt_id = 1'b0;
    cyc("t4d1", DRN, 1'b0, 6);
    bif.dmem_stall = 1'b1;
    cyc("t4f1", DRNF, 1'b0, 6);
    cyc("t4f2", DRNF, 1'b0, 6);
    bif.dmem_stall = 1'b0;
    cyc("t4d2", DRN, 1'b0, 6);
    cyc("t4halt", HLT, 1'b0, 6);
    bif.redirect_ex = 1'b1;
    bif.imem_stall  = 1'b1;
    cyc("t4stay", HLT, 1'b0, 6);
    clearIn();
    rst = 1'b1;
    cyc("rstHalt", ALL, 1'b0, -1);
    rst = 1'b0;

    // T6: sticky err, reset mid-drain
    bif.err_in = 1'b1;
    cyc("t6pulse", ALL, 1'b1, 0);
    bif.err_in = 1'b0;
    cyc("t6stick", ALL, 1'b1, 0);
    bif.halt_id = 1'b1;
    cyc("t6acc", HALTA, 1'b1, 0);
    bif.halt_id = 1'b0;
    cyc("t6drn", DRN, 1'b1, 0);
    rst = 1'b1;
    cyc("t6rst", ALL, 1'b0, -1);
    rst = 1'b0;
    cyc("t6run", ALL, 1'b0, 0);
    bif.halt_id = 1'b1;
    cyc("rlAcc", HALTA, 1'b0, 0);
    bif.halt_id = 1'b0;
    cyc("rlD1", DRN, 1'b0, 0);
    cyc("rlD2", DRN, 1'b0, 0);
    cyc("rlHalt", HLT, 1'b0, 0);
    rst = 1'b1;
    cyc("rst2", ALL, 1'b0, -1);
    rst = 1'b0;

    // T5: long freeze saturates counter
    for (int i = 0; i < 70000; i++) begin
      bif.dmem_stall = 1'b1;
      if (i == 0)
        cyc("t5start", NONE, 1'b0, 0);
      else if (i == 65534)
        cyc("t5pre", NONE, 1'b0, 65534);
      else if (i == 65535)
        cyc("t5sat", NONE, 1'b0, 65535);
      else if (i == 69999)
        cyc("t5end", NONE, 1'b0, 65535);
      else
        tick();
    end
    bif.dmem_stall = 1'b0;
    cyc("t5idle", ALL, 1'b0, 65535);
    bif.reg_write_ex = 1'b1;
    bif.wr_reg_ex    = 3'd6;
    bif.rt_id        = 3'd6;
    bif.rt_vld       = 1'b1;
    cyc("t5raw", RAWS, 1'b0, 65535);
    clearIn();
    cyc("t5nowrap", ALL, 1'b0, 65535);

    if (q.size() != 0)
      chk("qDrain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end

endmodule
